// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle CPU controller: opcodes, FSM states,
// datapath select codes and the decoded-opcode record.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTIU = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EXE_ALU = 4'd2,
    S_WB_ALU  = 4'd3,
    S_EXE_BR  = 4'd4,
    S_EXE_MEM = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_WB_LD   = 4'd8,
    S_HALT    = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_SLTU = 3'b010, ALU_SLT = 3'b011,
    ALU_SLL = 3'b100, ALU_OR  = 3'b101, ALU_AND  = 3'b110, ALU_XOR = 3'b111
  } aluop_e;

  typedef enum logic [1:0] {
    PC_INC = 2'b00, PC_BR = 2'b01, PC_RS = 2'b10, PC_JUMP = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_SHAMT = 2'b10
  } extsel_e;

  typedef enum logic [1:0] {
    RO_RA = 2'b00, RO_RT = 2'b01, RO_RD = 2'b10
  } regout_e;

  typedef enum logic [3:0] {
    CL_ALU_R, CL_ALU_I, CL_BR, CL_LW, CL_SW, CL_J, CL_JR, CL_JAL, CL_HALT, CL_ILL
  } op_class_e;

  typedef struct packed {
    op_class_e  cls;
    logic [2:0] aluop;
    logic       srcb;
    logic [1:0] ext;
    logic [1:0] regout;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the sequencing FSM (master) and the datapath (slave).
interface multicycle_ctrl_fsm_if;
  logic [5:0] op;
  logic       zero;
  logic       PCWre, IRWre, InsMemRW, RegWre, ALUSrcB, ALUM2Reg, WrRegData, DataMemRW;
  logic [1:0] ExtSel;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc;
  logic [1:0] RegOut;
  logic [3:0] state;
  logic       ill_op;

  modport master (
    input  op, zero,
    output PCWre, IRWre, InsMemRW, RegWre, ALUSrcB, ALUM2Reg, WrRegData, DataMemRW,
           ExtSel, ALUOp, PCSrc, RegOut, state, ill_op
  );

  modport slave (
    output op, zero,
    input  PCWre, IRWre, InsMemRW, RegWre, ALUSrcB, ALUM2Reg, WrRegData, DataMemRW,
           ExtSel, ALUOp, PCSrc, RegOut, state, ill_op
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_op_decode.sv
// Combinational opcode decode: instruction class plus the EXE-stage ALU
// controls and the write-back register select.
module ctrl_op_decode
  import cpu_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic [5:0] i_op,
  output dec_t       o_dec
);

  always_comb begin
    o_dec.cls    = CL_ILL;
    o_dec.aluop  = ALU_ADD;
    o_dec.srcb   = 1'b0;
    o_dec.ext    = EXT_ZERO;
    o_dec.regout = RO_RD;
    o_dec.legal  = 1'b1;
    // HALT_OP is checked first so a reassigned halt code always wins
    if (i_op == HALT_OP) begin
      o_dec.cls = CL_HALT;
    end else begin
      case (i_op)
        OP_ADD:   o_dec.cls = CL_ALU_R;
        OP_SUB:   begin o_dec.cls = CL_ALU_R; o_dec.aluop = ALU_SUB; end
        OP_OR:    begin o_dec.cls = CL_ALU_R; o_dec.aluop = ALU_OR;  end
        OP_AND:   begin o_dec.cls = CL_ALU_R; o_dec.aluop = ALU_AND; end
        OP_SLT:   begin o_dec.cls = CL_ALU_R; o_dec.aluop = ALU_SLT; end
        OP_SLL: begin
          o_dec.cls = CL_ALU_R; o_dec.aluop = ALU_SLL;
          o_dec.srcb = 1'b1;    o_dec.ext = EXT_SHAMT;
        end
        OP_ADDI: begin
          o_dec.cls = CL_ALU_I; o_dec.srcb = 1'b1;
          o_dec.ext = EXT_SIGN; o_dec.regout = RO_RT;
        end
        OP_ORI: begin
          o_dec.cls = CL_ALU_I; o_dec.aluop = ALU_OR; o_dec.srcb = 1'b1;
          o_dec.ext = EXT_ZERO; o_dec.regout = RO_RT;
        end
        OP_SLTIU: begin
          o_dec.cls = CL_ALU_I; o_dec.aluop = ALU_SLTU; o_dec.srcb = 1'b1;
          o_dec.ext = EXT_SIGN; o_dec.regout = RO_RT;
        end
        OP_SW:    begin o_dec.cls = CL_SW; o_dec.regout = RO_RT; end
        OP_LW:    begin o_dec.cls = CL_LW; o_dec.regout = RO_RT; end
        OP_BEQ:   o_dec.cls = CL_BR;
        OP_J:     o_dec.cls = CL_J;
        OP_JR:    o_dec.cls = CL_JR;
        OP_JAL:   o_dec.cls = CL_JAL;
        default:  o_dec.legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU controller: IF/ID/EXE/MEM/WB sequencer driving all datapath
// strobes. Optional PERF_CNT_EN adds cycle and retired-instruction counters.
module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP      = 6'b111111,
  parameter logic [1:0] LINK_REG_SEL = 2'b00
) (
  input  logic                 clk,
  input  logic                 RST,
  multicycle_ctrl_fsm_if.master bus
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]          cyc_cnt,
  output logic [31:0]          ret_cnt
`endif
);

  state_e     r_state, w_next;
  logic       r_ill;
  dec_t       w_dec;
  logic       w_pcwre, w_irwre, w_regwre, w_srcb, w_m2r, w_wrd, w_dmw;
  logic [1:0] w_ext, w_pcsrc, w_regout;
  logic [2:0] w_aluop;

  ctrl_op_decode #(.HALT_OP(HALT_OP)) u_dec (.i_op(bus.op), .o_dec(w_dec));

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state <= S_IF;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ID && !w_dec.legal) r_ill <= 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_pcwre  = 1'b0;
    w_irwre  = 1'b0;
    w_regwre = 1'b0;
    w_srcb   = 1'b0;
    w_m2r    = 1'b0;
    w_wrd    = 1'b0;
    w_dmw    = 1'b0;
    w_ext    = EXT_ZERO;
    w_aluop  = ALU_ADD;
    w_pcsrc  = PC_INC;
    w_regout = RO_RA;
    case (r_state)
      S_IF: begin
        w_irwre = 1'b1;
        w_next  = S_ID;
      end
      S_ID: begin
        case (w_dec.cls)
          CL_J:    begin w_pcsrc = PC_JUMP; w_pcwre = 1'b1; w_next = S_IF; end
          CL_JR:   begin w_pcsrc = PC_RS;   w_pcwre = 1'b1; w_next = S_IF; end
          CL_JAL: begin
            // link write of PC+4 into $31 happens alongside the jump
            w_pcsrc  = PC_JUMP; w_pcwre = 1'b1; w_regwre = 1'b1;
            w_regout = LINK_REG_SEL; w_wrd = 1'b0; w_next = S_IF;
          end
          CL_HALT, CL_ILL: w_next = S_HALT;
          CL_BR:           w_next = S_EXE_BR;
          CL_LW, CL_SW:    w_next = S_EXE_MEM;
          default:         w_next = S_EXE_ALU;
        endcase
      end
      S_EXE_ALU: begin
        w_aluop = w_dec.aluop;
        w_srcb  = w_dec.srcb;
        w_ext   = w_dec.ext;
        w_next  = S_WB_ALU;
      end
      S_WB_ALU: begin
        w_regwre = 1'b1; w_wrd = 1'b1; w_pcwre = 1'b1;
        w_regout = w_dec.regout;
        w_next   = S_IF;
      end
      S_EXE_BR: begin
        w_aluop = ALU_SUB; w_ext = EXT_SIGN; w_pcwre = 1'b1;
        w_pcsrc = bus.zero ? PC_BR : PC_INC;
        w_next  = S_IF;
      end
      S_EXE_MEM: begin
        w_aluop = ALU_ADD; w_srcb = 1'b1; w_ext = EXT_SIGN;
        w_next  = (w_dec.cls == CL_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_WR: begin
        w_dmw = 1'b1; w_pcwre = 1'b1;
        w_next = S_IF;
      end
      S_MEM_RD: begin
        w_m2r  = 1'b1;
        w_next = S_WB_LD;
      end
      S_WB_LD: begin
        w_regwre = 1'b1; w_regout = RO_RT; w_wrd = 1'b1; w_m2r = 1'b1; w_pcwre = 1'b1;
        w_next   = S_IF;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  assign bus.PCWre     = w_pcwre;
  assign bus.IRWre     = w_irwre;
  assign bus.InsMemRW  = 1'b0;
  assign bus.RegWre    = w_regwre;
  assign bus.ALUSrcB   = w_srcb;
  assign bus.ALUM2Reg  = w_m2r;
  assign bus.WrRegData = w_wrd;
  assign bus.DataMemRW = w_dmw;
  assign bus.ExtSel    = w_ext;
  assign bus.ALUOp     = w_aluop;
  assign bus.PCSrc     = w_pcsrc;
  assign bus.RegOut    = w_regout;
  assign bus.state     = r_state;
  assign bus.ill_op    = r_ill;

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (r_state != S_HALT) cyc_cnt <= cyc_cnt + 32'd1;
      if (w_pcwre)           ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-instruction expected cycle tables fed
// through a scoreboard queue, plus reset/halt/illegal-opcode sequences.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, rw, dmw, m2r, wrd, srcb;
    logic [1:0] ext;
    logic [2:0] alu;
    logic [1:0] pcs;
    logic [1:0] ro;
  } outs_t;

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic       z;
    int         len;
    outs_t      c1, c2, c3, c4;
  } vec_t;

  logic clk = 1'b0;
  logic RST;
  int   n_chk = 0;
  int   n_fail = 0;
  outs_t sb[$];
  vec_t  vt[16];

  multicycle_ctrl_fsm_if bus ();
  multicycle_ctrl_fsm dut (.clk(clk), .RST(RST), .bus(bus.master));

  always #5 clk = ~clk;

  function automatic outs_t o(input logic [3:0] st, input logic pcw, irw, rw, dmw, m2r,
                              wrd, srcb, input logic [1:0] ext, input logic [2:0] alu,
                              input logic [1:0] pcs, ro);
    outs_t r;
    r = '{st, pcw, irw, rw, dmw, m2r, wrd, srcb, ext, alu, pcs, ro};
    return r;
  endfunction

  function automatic outs_t cap();
    outs_t r;
    r = '{bus.state, bus.PCWre, bus.IRWre, bus.RegWre, bus.DataMemRW, bus.ALUM2Reg,
          bus.WrRegData, bus.ALUSrcB, bus.ExtSel, bus.ALUOp, bus.PCSrc, bus.RegOut};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input string nm, input logic [5:0] op, input logic z,
                               input int len, input outs_t c1, c2, c3, c4);
    vec_t v;
    v.nm = nm; v.op = op; v.z = z; v.len = len;
    v.c1 = c1; v.c2 = c2; v.c3 = c3; v.c4 = c4;
    return v;
  endfunction

  // Called just after a falling edge with the DUT in IF.
  task automatic run_vec(input vec_t v);
    outs_t e, a;
    sb.push_back(o(0,0,1,0,0,0,0,0,0,0,0,0));
    sb.push_back(v.c1);
    if (v.len > 2) sb.push_back(v.c2);
    if (v.len > 3) sb.push_back(v.c3);
    if (v.len > 4) sb.push_back(v.c4);
    for (int c = 0; c < v.len; c++) begin
      if (c > 0) @(negedge clk);
      // op garbage in IF is harmless: the IR only changes on the IF edge
      bus.op = (c == 0) ? 6'b101010 : v.op;
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      bus.zero = (e.st == 4'd4) ? v.z : 1'($urandom_range(1));
      #1;
      a = cap();
      chk($sformatf("%s_c%0d", v.nm, c), 32'(a), 32'(e));
    end
    @(negedge clk);
  endtask

  outs_t IFo, ID0, WBR, WBI, EXM, MWR, MRD, WBL, FILL;

  initial begin
    IFo  = o(0,0,1,0,0,0,0,0,0,0,0,0);
    ID0  = o(1,0,0,0,0,0,0,0,0,0,0,0);
    WBR  = o(3,1,0,1,0,0,1,0,0,0,0,2'b10);
    WBI  = o(3,1,0,1,0,0,1,0,0,0,0,2'b01);
    EXM  = o(5,0,0,0,0,0,0,1,2'b01,3'b000,0,0);
    MWR  = o(7,1,0,0,1,0,0,0,0,0,0,0);
    MRD  = o(6,0,0,0,0,1,0,0,0,0,0,0);
    WBL  = o(8,1,0,1,0,1,1,0,0,0,0,2'b01);
    FILL = IFo;
    vt[0]  = mkv("add",   6'b000000, 0, 4, ID0, o(2,0,0,0,0,0,0,0,2'b00,3'b000,0,0), WBR, FILL);
    vt[1]  = mkv("sub",   6'b000001, 0, 4, ID0, o(2,0,0,0,0,0,0,0,2'b00,3'b001,0,0), WBR, FILL);
    vt[2]  = mkv("addi",  6'b000010, 1, 4, ID0, o(2,0,0,0,0,0,0,1,2'b01,3'b000,0,0), WBI, FILL);
    vt[3]  = mkv("or",    6'b010000, 0, 4, ID0, o(2,0,0,0,0,0,0,0,2'b00,3'b101,0,0), WBR, FILL);
    vt[4]  = mkv("and",   6'b010001, 1, 4, ID0, o(2,0,0,0,0,0,0,0,2'b00,3'b110,0,0), WBR, FILL);
    vt[5]  = mkv("ori",   6'b010010, 0, 4, ID0, o(2,0,0,0,0,0,0,1,2'b00,3'b101,0,0), WBI, FILL);
    vt[6]  = mkv("sll",   6'b011000, 0, 4, ID0, o(2,0,0,0,0,0,0,1,2'b10,3'b100,0,0), WBR, FILL);
    vt[7]  = mkv("slt",   6'b100110, 1, 4, ID0, o(2,0,0,0,0,0,0,0,2'b00,3'b011,0,0), WBR, FILL);
    vt[8]  = mkv("sltiu", 6'b100111, 0, 4, ID0, o(2,0,0,0,0,0,0,1,2'b01,3'b010,0,0), WBI, FILL);
    vt[9]  = mkv("sw",    6'b110000, 0, 4, ID0, EXM, MWR, FILL);
    vt[10] = mkv("lw",    6'b110001, 0, 5, ID0, EXM, MRD, WBL);
    vt[11] = mkv("beq_z1",6'b110100, 1, 3, ID0, o(4,1,0,0,0,0,0,0,2'b01,3'b001,2'b01,0), FILL, FILL);
    vt[12] = mkv("beq_z0",6'b110100, 0, 3, ID0, o(4,1,0,0,0,0,0,0,2'b01,3'b001,2'b00,0), FILL, FILL);
    vt[13] = mkv("j",     6'b111000, 0, 2, o(1,1,0,0,0,0,0,0,0,0,2'b11,0), FILL, FILL, FILL);
    vt[14] = mkv("jr",    6'b111001, 0, 2, o(1,1,0,0,0,0,0,0,0,0,2'b10,0), FILL, FILL, FILL);
    vt[15] = mkv("jal",   6'b111010, 0, 2, o(1,1,0,1,0,0,0,0,0,0,2'b11,2'b00), FILL, FILL, FILL);

    RST = 1'b1; bus.op = 6'd0; bus.zero = 1'b0;
    @(negedge clk); #1;
    chk("rst_outs", 32'(cap()), 32'(IFo));
    chk("rst_ill", 32'(bus.ill_op), 32'd0);
    chk("rst_imrw", 32'(bus.InsMemRW), 32'd0);
    @(negedge clk); RST = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(vt[i]);

    // reset while in EXE_ALU of an add
    bus.op = 6'b000000;
    @(negedge clk); @(negedge clk); #1;
    chk("pre_rst_state", 32'(bus.state), 32'd2);
    RST = 1'b1; #1;
    chk("midrst_state", 32'(bus.state), 32'd0);
    chk("midrst_regwre", 32'(bus.RegWre), 32'd0);
    chk("midrst_irwre", 32'(bus.IRWre), 32'd1);
    @(negedge clk); #1;
    chk("rsthold_outs", 32'(cap()), 32'(IFo));
    RST = 1'b0;
    @(negedge clk); #1; chk("postrst_id", 32'(bus.state), 32'd1);
    @(negedge clk); #1; chk("postrst_exe", 32'(bus.state), 32'd2);
    @(negedge clk); #1; chk("postrst_wb", 32'(cap()), 32'(WBR));
    @(negedge clk);

    // halt opcode parks the FSM with no strobes and no ill_op
    bus.op = 6'b111111;
    @(negedge clk); #1; chk("halt_id", 32'(cap()), 32'(ID0));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); bus.zero = 1'($urandom_range(1)); bus.op = 6'($urandom); #1;
      chk($sformatf("halt_c%0d", k), 32'(cap()), 32'(o(9,0,0,0,0,0,0,0,0,0,0,0)));
      if (k % 5 == 0) chk("halt_ill", 32'(bus.ill_op), 32'd0);
    end
    RST = 1'b1; @(negedge clk); RST = 1'b0;

    // undefined opcode: HALT with sticky ill_op until reset
    bus.op = 6'b101010;
    @(negedge clk); #1; chk("ill_id_flag", 32'(bus.ill_op), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("ill_state", 32'(bus.state), 32'd9);
      chk("ill_flag", 32'(bus.ill_op), 32'd1);
    end
    RST = 1'b1; #1;
    chk("ill_clr", 32'(bus.ill_op), 32'd0);
    chk("ill_rst_state", 32'(bus.state), 32'd0);
    @(negedge clk); RST = 1'b0;
    run_vec(vt[10]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- State-machine controller that sequences the multicycle CPU datapath through IF / ID / EXE / MEM / WB.
- Takes the opcode from the instruction register and the ALU zero flag.
- Drives every datapath control strobe: PC, IR, register file, ALU, data RAM and the selectors.
- Sits beside the datapath at top level. It replaces hand-driven control inputs with a self-sequencing unit.

Parameters:
- HALT_OP, 6'b111111, opcode that parks the FSM in HALT.
- LINK_REG_SEL, 2'b00, RegOut code that selects $31 for jal.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous active-high reset.
- op  in  6  instruction[31:26] from the IR output.
- zero  in  1  ALU zero flag.
- PCWre  out  1  PC load enable.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  instruction memory R/W; constant 0 (read).
- RegWre  out  1  register file write enable.
- ALUSrcB  out  1  0 = register B, 1 = extended immediate.
- ALUM2Reg  out  1  0 = ALU result, 1 = memory data to the write-back register.
- WrRegData  out  1  0 = PC+4 (link), 1 = write-back register.
- DataMemRW  out  1  1 = write data RAM.
- ExtSel  out  2  00 zero-extend, 01 sign-extend, 10 shamt instr[10:6].
- ALUOp  out  3  000 ADD, 001 SUB, 010 SLTU, 011 SLT, 100 SLL, 101 OR, 110 AND, 111 XOR.
- PCSrc  out  2  00 PC+4, 01 PC+4+(imm<<2), 10 rs, 11 jump target.
- RegOut  out  2  00 $31, 01 rt, 10 rd.
- state  out  4  current state code, for debug.
- ill_op  out  1  sticky flag: an undefined opcode was decoded.

Behaviour:
- Reset:
  - Asynchronous; takes effect immediately, even mid-instruction.
  - State returns to IF and ill_op clears.
  - All outputs take their IF-state values: IRWre=1, all other strobes 0, selects 0.
  - No RegWre, DataMemRW or PCWre pulse may occur while RST is high.
- Output timing:
  - Outputs are combinational decodes of state plus op.
  - In EXE_BR only, PCSrc also depends on zero.
  - Every write strobe is high for exactly one cycle.
- States and transitions:
  - IF: IRWre=1. Next state ID.
  - ID: decode op.
    - j: PCSrc=11, PCWre=1, next IF.
    - jr: PCSrc=10, PCWre=1, next IF.
    - jal: PCSrc=11, RegWre=1, RegOut=00, WrRegData=0, PCWre=1, next IF.
    - HALT_OP: next HALT.
    - Undefined opcode: set ill_op, next HALT.
    - beq: next EXE_BR.
    - lw / sw: next EXE_MEM.
    - All other defined opcodes: next EXE_ALU.
  - EXE_ALU: ALUOp, ALUSrcB and ExtSel from the opcode table in the package. Next WB_ALU.
  - WB_ALU: RegWre=1, ALUM2Reg=0, WrRegData=1, PCWre=1, PCSrc=00.
    - RegOut=10 for R-type, 01 for I-type. Next IF.
  - EXE_BR: ALUOp=SUB, ALUSrcB=0, ExtSel=01, PCWre=1, PCSrc = zero ? 01 : 00. Next IF.
  - EXE_MEM: ALUOp=ADD, ALUSrcB=1, ExtSel=01. Next MEM_RD for lw, MEM_WR for sw.
  - MEM_WR: DataMemRW=1, PCWre=1, PCSrc=00. Next IF.
  - MEM_RD: DataMemRW=0, ALUM2Reg=1. Next WB_LD.
  - WB_LD: RegWre=1, RegOut=01, WrRegData=1, ALUM2Reg=1, PCWre=1, PCSrc=00. Next IF.
  - HALT: all strobes 0. The FSM stays here until RST.
- Latency in cycles:
  - j / jr / jal = 2
  - beq = 3
  - ALU ops and sw = 4
  - lw = 5
- Boundary cases:
  - op changing outside ID, EXE_* or MEM_* has no effect, because IR is only loaded in IF.
  - zero is ignored outside EXE_BR.
  - A zero glitch in EXE_BR follows the PCSrc decode; the datapath samples it at the edge.

Optional Feature:
- Macro PERF_CNT_EN.
- When defined, adds 32-bit output ports cyc_cnt and ret_cnt.
  - cyc_cnt increments every non-HALT cycle.
  - ret_cnt increments on each PCWre pulse.
  - Both clear on RST and wrap modulo 2^32.
- When undefined, the counters and ports are absent; the rest of the behaviour is identical.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the opcode constants (add, sub, addi, or, and, ori, sll, slt, sltiu, sw, lw, beq, j, jr, jal, halt);
  - the state enum;
  - the ALUOp, PCSrc, ExtSel and RegOut encodings.
- One sub-module, ctrl_op_decode: combinational opcode to {class, ALUOp, ALUSrcB, ExtSel, RegOut, legal}.

Test Plan:
- Reset mid-EXE_ALU: RST pulse -> state=IF the same cycle, RegWre=0, next cycles run IF->ID.
- add: 4 cycles. RegWre=1 and RegOut=10 only in cycle 4; PCWre=1 in cycle 4 only.
- lw: 5 cycles. MEM_RD has DataMemRW=0; WB_LD has RegWre=1, ALUM2Reg=1, RegOut=01.
- beq:
  - zero=1 -> PCSrc=01 and PCWre=1 in cycle 3.
  - zero=0 -> PCSrc=00.
- jal: 2 cycles, ID has RegOut=00, WrRegData=0, RegWre=1, PCSrc=11.
- halt op 6'b111111 -> state=HALT, all strobes 0 for 20 cycles, ill_op=0.
- Opcode 6'b101010 -> HALT with ill_op=1 until RST.
